// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM states, counter sizing
// and the upper bound on the number of sequenced outputs.
package rst_seq_pkg;

    localparam int MAX_NUM_OUT = 8;
    localparam int IDX_W       = $clog2(MAX_NUM_OUT);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_STRETCH,
        ST_RELEASE,
        ST_DONE
    } seqState_e;

    // Wide enough to hold the larger of the two delays without wrapping.
    function automatic int cntWidth(input int stretch, input int gap);
        return $clog2(((stretch > gap) ? stretch : gap) + 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// CHAINS-deep deassertion synchroniser: cleared asynchronously, shifts in 1
// so the output rises CHAINS edges after the reset input goes high.
module rst_sync_chain #(
    parameter int CHAINS = 2
) (
    input  logic clk,
    input  logic async_rst_i,
    output logic sync_o
);

    logic [CHAINS-1:0] chain_q;

    always_ff @(posedge clk or negedge async_rst_i) begin
        if (!async_rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[CHAINS-2:0], 1'b1};
        end
    end

    assign sync_o = chain_q[CHAINS-1];

endmodule

// File: rtl/rst_seq_sync.sv
// Reset synchroniser and sequencer: releases NUM_OUT resets in order after a
// synchronised deassertion. Define RST_SEQ_CNT_EN to add the soft-reset counter.
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int   CHAINS  = 2,
    parameter int   NUM_OUT = 3,
    parameter int   STRETCH = 4,
    parameter int   GAP     = 3,
    parameter logic RST_POL = 1'b1
) (
    input  logic               clk,
    input  logic               async_rst_i,
    input  logic               soft_rst_i,
    output logic [NUM_OUT-1:0] rst_o,
`ifdef RST_SEQ_CNT_EN
    output logic [7:0]         rst_cnt_o,
`endif
    output logic               rst_done_o
);

    localparam int CNT_W = cntWidth(STRETCH, GAP);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic syncRelease;

    seqState_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic               done_q, done_d;
    logic               startRelease;

    rst_sync_chain #(
        .CHAINS(CHAINS)
    ) u_sync (
        .clk        (clk),
        .async_rst_i(async_rst_i),
        .sync_o     (syncRelease)
    );

    always_ff @(posedge clk or negedge async_rst_i) begin
        if (!async_rst_i) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= {NUM_OUT{RST_POL}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
        end
    end

    // The synchroniser rose one edge before HOLD sees it, so that edge already
    // counts as the first stretch cycle.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rst_d        = rst_q;
        done_d       = done_q;
        startRelease = 1'b0;

        case (state_q)
            ST_HOLD: begin
                if (syncRelease) begin
                    if (STRETCH == 1) begin
                        startRelease = 1'b1;
                    end else begin
                        state_d = ST_STRETCH;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_STRETCH: begin
                if (cnt_q == CNT_W'(STRETCH - 1)) begin
                    startRelease = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    cnt_d = '0;
                    for (int k = 0; k < NUM_OUT; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            rst_d[k] = ~RST_POL;
                        end
                    end
                    if (idx_q == IDX_W'(NUM_OUT - 1)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        if (startRelease) begin
            rst_d[0] = ~RST_POL;
            cnt_d    = '0;
            idx_d    = IDX_W'(1);
            if (NUM_OUT == 1) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end else begin
                state_d = ST_RELEASE;
            end
        end

        // Soft reset overrides any release due on the same edge.
        if (soft_rst_i && (state_q != ST_HOLD)) begin
            state_d = ST_STRETCH;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = {NUM_OUT{RST_POL}};
            done_d  = 1'b0;
        end
    end

    assign rst_o      = rst_q;
    assign rst_done_o = done_q;

`ifdef RST_SEQ_CNT_EN
    logic       softPrev_q;
    logic [7:0] softCnt_q, softCnt_d;

    always_comb begin
        softCnt_d = softCnt_q;
        if (soft_rst_i && !softPrev_q && (softCnt_q != 8'hFF)) begin
            softCnt_d = softCnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge async_rst_i) begin
        if (!async_rst_i) begin
            softPrev_q <= 1'b0;
            softCnt_q  <= '0;
        end else begin
            softPrev_q <= soft_rst_i;
            softCnt_q  <= softCnt_d;
        end
    end

    assign rst_cnt_o = softCnt_q;
`endif

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: release-time model against the DUT every cycle,
// directed scenarios plus random soft/async resets. RST_SEQ_CNT_EN adds counter tests.
module tb_rst_seq_sync;

    localparam int   CHAINS  = 2;
    localparam int   NUM_OUT = 3;
    localparam int   STRETCH = 4;
    localparam int   GAP     = 3;
    localparam logic RST_POL = 1'b1;

    logic               clk = 1'b0;
    logic               asyncRst;
    logic               softRst;
    logic [NUM_OUT-1:0] rstOut;
    logic               rstDone;
`ifdef RST_SEQ_CNT_EN
    logic [7:0]         rstCnt;
    int                 cntModel = 0;
    logic               prevSoft = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int n      = 0;
    int anchor = CHAINS;

    always #5 clk = ~clk;

    rst_seq_sync #(
        .CHAINS (CHAINS),
        .NUM_OUT(NUM_OUT),
        .STRETCH(STRETCH),
        .GAP    (GAP),
        .RST_POL(RST_POL)
    ) dut (
        .clk        (clk),
        .async_rst_i(asyncRst),
        .soft_rst_i (softRst),
        .rst_o      (rstOut),
`ifdef RST_SEQ_CNT_EN
        .rst_cnt_o  (rstCnt),
`endif
        .rst_done_o (rstDone)
    );

    // Model: n counts edges since async release (E1 = 1); output k is released
    // once n - anchor >= STRETCH + k*GAP, where anchor is E_CHAINS or the last
    // honoured soft-reset edge. Soft resets count only after HOLD is left.
    always @(posedge clk or negedge asyncRst) begin
        if (!asyncRst) begin
            n      = 0;
            anchor = CHAINS;
`ifdef RST_SEQ_CNT_EN
            cntModel = 0;
            prevSoft = 1'b0;
`endif
        end else begin
            n = n + 1;
            if (softRst && (n >= CHAINS + 2)) anchor = n;
`ifdef RST_SEQ_CNT_EN
            if (softRst && !prevSoft && (cntModel < 255)) cntModel = cntModel + 1;
            prevSoft = softRst;
`endif
        end
    end

    function automatic logic [NUM_OUT-1:0] expRst();
        logic [NUM_OUT-1:0] e;
        for (int k = 0; k < NUM_OUT; k++) begin
            e[k] = (n - anchor >= STRETCH + k * GAP) ? ~RST_POL : RST_POL;
        end
        return e;
    endfunction

    function automatic logic expDone();
        return (n - anchor >= STRETCH + (NUM_OUT - 1) * GAP);
    endfunction

    task automatic checkOutput(input string tag);
        logic [NUM_OUT-1:0] e;
        e = expRst();
        checks++;
        if (rstOut !== e) begin
            errors++;
            $display("[TB] FAIL %s rst_o got %b want %b (n=%0d) t=%0t", tag, rstOut, e, n, $time);
        end
        checks++;
        if (rstDone !== expDone()) begin
            errors++;
            $display("[TB] FAIL %s rst_done_o got %b want %b (n=%0d) t=%0t", tag, rstDone, expDone(), n, $time);
        end
`ifdef RST_SEQ_CNT_EN
        checks++;
        if (rstCnt !== 8'(cntModel)) begin
            errors++;
            $display("[TB] FAIL %s rst_cnt_o got %0d want %0d t=%0t", tag, rstCnt, cntModel, $time);
        end
`endif
    endtask

    task automatic checkLit(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Inputs change 2 time units after the falling edge, well clear of posedge.
    task automatic tick(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            #2;
        end
    endtask

    always @(negedge clk) checkOutput("cycle");

    task automatic applyStimulus();
        asyncRst = 1'b1;
        tick(5);
        checkLit("e5_rst", 32'(rstOut), 32'b111);
        tick(1);
        checkLit("e6_rst", 32'(rstOut), 32'b110);
        tick(3);
        checkLit("e9_rst", 32'(rstOut), 32'b100);
        checkLit("e9_done", 32'(rstDone), 32'd0);
        tick(3);
        checkLit("e12_rst", 32'(rstOut), 32'b000);
        checkLit("e12_done", 32'(rstDone), 32'd1);
    endtask

    int holdCnt;

    initial begin
        asyncRst = 1'b1;
        softRst  = 1'b0;
        #1 asyncRst = 1'b0;
        tick(2);
        checkLit("reset_rst", 32'(rstOut), 32'b111);
        checkLit("reset_done", 32'(rstDone), 32'd0);

        $display("[TB] basic release sequence");
        applyStimulus();

        $display("[TB] async reset during RELEASE");
        asyncRst = 1'b0;
        tick(2);
        asyncRst = 1'b1;
        tick(7);
        checkLit("pre_drop_rst", 32'(rstOut), 32'b110);
        asyncRst = 1'b0;
        #1;
        checkLit("drop_rst", 32'(rstOut), 32'b111);
        checkLit("drop_done", 32'(rstDone), 32'd0);
        tick(2);
        applyStimulus();

        $display("[TB] single-cycle soft reset in DONE");
        tick(2);
        softRst = 1'b1;
        tick(1);
        softRst = 1'b0;
        checkLit("soft_s_rst", 32'(rstOut), 32'b111);
        checkLit("soft_s_done", 32'(rstDone), 32'd0);
        tick(3);
        checkLit("soft_s3_rst", 32'(rstOut), 32'b111);
        tick(1);
        checkLit("soft_s4_rst", 32'(rstOut), 32'b110);
        tick(3);
        checkLit("soft_s7_rst", 32'(rstOut), 32'b100);
        tick(3);
        checkLit("soft_s10_rst", 32'(rstOut), 32'b000);

        $display("[TB] held soft reset during STRETCH");
        asyncRst = 1'b0;
        tick(2);
        asyncRst = 1'b1;
        tick(4);
        softRst = 1'b1;
        tick(5);
        softRst = 1'b0;
        checkLit("held_e9_rst", 32'(rstOut), 32'b111);
        tick(3);
        checkLit("held_e12_rst", 32'(rstOut), 32'b111);
        tick(1);
        checkLit("held_e13_rst", 32'(rstOut), 32'b110);
        tick(6);
        checkLit("held_e19_done", 32'(rstDone), 32'd1);

        $display("[TB] soft reset colliding with rst_o[1] release");
        asyncRst = 1'b0;
        tick(2);
        asyncRst = 1'b1;
        tick(8);
        checkLit("clash_pre_rst", 32'(rstOut), 32'b110);
        softRst = 1'b1;
        tick(1);
        softRst = 1'b0;
        checkLit("clash_rst", 32'(rstOut), 32'b111);
        tick(4);
        checkLit("clash_e13_rst", 32'(rstOut), 32'b110);
        tick(6);
        checkLit("clash_e19_rst", 32'(rstOut), 32'b000);

`ifdef RST_SEQ_CNT_EN
        $display("[TB] soft reset counter saturation");
        asyncRst = 1'b0;
        tick(2);
        checkLit("cnt_reset", 32'(rstCnt), 32'd0);
        asyncRst = 1'b1;
        repeat (300) begin
            softRst = 1'b1;
            tick(1);
            softRst = 1'b0;
            tick(1);
        end
        checkLit("cnt_sat", 32'(rstCnt), 32'd255);
        asyncRst = 1'b0;
        #1;
        checkLit("cnt_clear", 32'(rstCnt), 32'd0);
        tick(2);
`endif

        $display("[TB] randomized soft/async reset traffic");
        asyncRst = 1'b0;
        tick(1);
        asyncRst = 1'b1;
        holdCnt  = 0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (!asyncRst) begin
                if (holdCnt == 0) asyncRst = 1'b1;
                else holdCnt--;
            end else if ($urandom_range(0, 249) == 0) begin
                asyncRst = 1'b0;
                holdCnt  = $urandom_range(0, 2);
                #1;
                checkOutput("async_drop");
            end
            if ((i / 500) % 2 == 0) softRst = ($urandom_range(0, 24) == 0);
            else                    softRst = ($urandom_range(0, 3) == 0);
        end
        softRst = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
